// File: rtl/signal_conflict_monitor.sv
// -----------------------------------------------------------------------------
// signal_conflict_monitor
//   Independent watchdog on the four [R Y G] aspect buses of an intersection
//   controller. It detects conflicting greens, malformed aspects, bad yellow
//   sequencing and a stalled controller. It then latches a fault code, drives a
//   flash-enable for the fail-safe relay, and holds until fault_clear is given
//   and an all-red interval has been verified.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   main_road_1     : aspect [R Y G], road 0
//   main_road_2     : aspect [R Y G], road 1
//   main_turn       : aspect [R Y G], road 2
//   side_road       : aspect [R Y G], road 3
//   preempt         : emergency preemption active (masks skip-yellow)
//   fault_clear     : single-cycle request to leave FAULT
//   fault           : high in FAULT and RECOVER
//   fault_code      : 1 CONFLICT 2 INVALID 3 SKIP_YELLOW 4 SHORT_YELLOW
//                     5 YEL_TO_GREEN 6 STUCK, 0 none
//   fault_road      : offending road (lower index of a conflicting pair)
//   flash_on        : fail-safe flash drive
//   fault_count     : saturating count of FAULT entries
//   monitor_ok      : high only in MONITOR
// -----------------------------------------------------------------------------
module signal_conflict_monitor #(
  parameter int MIN_YELLOW   = 3,
  parameter int INVALID_CYC  = 1,
  parameter int MAX_STUCK    = 32,
  parameter int PREEMPT_HOLD = 16,
  parameter int FLASH_HALF   = 4,
  parameter int ALLRED_CYC   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] main_road_1,
  input  logic [2:0] main_road_2,
  input  logic [2:0] main_turn,
  input  logic [2:0] side_road,
  input  logic       preempt,
  input  logic       fault_clear,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_road,
  output logic       flash_on,
  output logic [7:0] fault_count,
  output logic       monitor_ok
);

  localparam logic [2:0] ASP_RED = 3'b100;
  localparam logic [2:0] ASP_YEL = 3'b010;
  localparam logic [2:0] ASP_GRN = 3'b001;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_CONFLICT  = 3'd1;
  localparam logic [2:0] FC_INVALID   = 3'd2;
  localparam logic [2:0] FC_SKIP_YEL  = 3'd3;
  localparam logic [2:0] FC_SHORT_YEL = 3'd4;
  localparam logic [2:0] FC_YEL_GRN   = 3'd5;
  localparam logic [2:0] FC_STUCK     = 3'd6;

  typedef enum logic [1:0] {ST_MONITOR, ST_FAULT, ST_RECOVER} state_t;

  state_t r_state, w_state_nxt;

  logic [3:0][2:0] w_in, r_cur, r_prev;
  logic [3:0][7:0] r_yel_run;
  logic [3:0][3:0] r_inv_cnt;
  logic [7:0]      r_stall, r_hold, r_flash_cnt, r_allred;
  logic [3:0]      w_red, w_yel, w_grn, w_prv_yel, w_prv_grn, w_bad, w_act;
  logic            w_in_allred, w_skip_mask;
  logic            w_det;
  logic [2:0]      w_code;
  logic [1:0]      w_road;
  logic            w_conf_hit, w_inv_hit, w_skip_hit, w_short_hit, w_y2g_hit, w_stuck_hit;
  logic [1:0]      w_conf_road, w_inv_road, w_skip_road, w_short_road, w_y2g_road;

  assign w_in        = {side_road, main_turn, main_road_2, main_road_1};
  assign w_in_allred = (w_in == {4{ASP_RED}});
  assign w_skip_mask = preempt || (r_hold != 8'd0);

  // Sample stage: cur is this cycle's aspect vector, prev the one before it.
  // NOTE: sequential state uses non-blocking (<=) so every register sees the
  // pre-edge value of the others; blocking here would collapse prev into cur.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur  <= {4{ASP_RED}};
      r_prev <= {4{ASP_RED}};
    end else begin
      r_cur  <= w_in;
      r_prev <= r_cur;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_red[i]     = (r_cur[i] == ASP_RED);
      w_yel[i]     = (r_cur[i] == ASP_YEL);
      w_grn[i]     = (r_cur[i] == ASP_GRN);
      w_prv_yel[i] = (r_prev[i] == ASP_YEL);
      w_prv_grn[i] = (r_prev[i] == ASP_GRN);
      w_bad[i]     = !(w_red[i] || w_yel[i] || w_grn[i]);
      w_act[i]     = w_yel[i] || w_grn[i];
    end
  end

  // Fault detection. Per-type checks are written highest road/pair first so
  // the last match, i.e. the lowest index, wins.
  // NOTE: every combinational output gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    w_conf_hit  = 1'b0;  w_conf_road  = 2'd0;
    w_inv_hit   = 1'b0;  w_inv_road   = 2'd0;
    w_skip_hit  = 1'b0;  w_skip_road  = 2'd0;
    w_short_hit = 1'b0;  w_short_road = 2'd0;
    w_y2g_hit   = 1'b0;  w_y2g_road   = 2'd0;
    w_det       = 1'b0;  w_code       = FC_NONE;  w_road = 2'd0;

    // Conflicting pairs: MT-S, M2-S, M2-MT, M1-S. M1-M2 and M1-MT may run together.
    if (w_act[2] && w_act[3]) begin w_conf_hit = 1'b1; w_conf_road = 2'd2; end
    if (w_act[1] && w_act[3]) begin w_conf_hit = 1'b1; w_conf_road = 2'd1; end
    if (w_act[1] && w_act[2]) begin w_conf_hit = 1'b1; w_conf_road = 2'd1; end
    if (w_act[0] && w_act[3]) begin w_conf_hit = 1'b1; w_conf_road = 2'd0; end

    for (int i = 3; i >= 0; i--) begin
      if (w_bad[i] && (r_inv_cnt[i] == 4'(INVALID_CYC - 1))) begin
        w_inv_hit = 1'b1;  w_inv_road = 2'(i);
      end
      if (!w_skip_mask && w_prv_grn[i] && w_red[i]) begin
        w_skip_hit = 1'b1;  w_skip_road = 2'(i);
      end
      // The run counter holds the yellow samples up to and including prev.
      if (w_prv_yel[i] && w_red[i] && (r_yel_run[i] < 8'(MIN_YELLOW))) begin
        w_short_hit = 1'b1;  w_short_road = 2'(i);
      end
      if (w_prv_yel[i] && w_grn[i]) begin
        w_y2g_hit = 1'b1;  w_y2g_road = 2'(i);
      end
    end

    w_stuck_hit = (r_cur == r_prev) && (r_stall == 8'(MAX_STUCK - 1));

    if      (w_conf_hit)  begin w_det = 1'b1; w_code = FC_CONFLICT;  w_road = w_conf_road;  end
    else if (w_inv_hit)   begin w_det = 1'b1; w_code = FC_INVALID;   w_road = w_inv_road;   end
    else if (w_skip_hit)  begin w_det = 1'b1; w_code = FC_SKIP_YEL;  w_road = w_skip_road;  end
    else if (w_short_hit) begin w_det = 1'b1; w_code = FC_SHORT_YEL; w_road = w_short_road; end
    else if (w_y2g_hit)   begin w_det = 1'b1; w_code = FC_YEL_GRN;   w_road = w_y2g_road;   end
    else if (w_stuck_hit) begin w_det = 1'b1; w_code = FC_STUCK;     w_road = 2'd0;         end
  end

  // History counters run only in MONITOR and sit at zero otherwise, so they
  // restart cleanly on the return from RECOVER. The preempt hold always runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_yel_run <= '0;
      r_inv_cnt <= '0;
      r_stall   <= '0;
      r_hold    <= '0;
    end else begin
      if (preempt)               r_hold <= 8'(PREEMPT_HOLD);
      else if (r_hold != 8'd0)   r_hold <= r_hold - 8'd1;

      if (r_state == ST_MONITOR) begin
        for (int i = 0; i < 4; i++) begin
          if (!w_yel[i])                 r_yel_run[i] <= 8'd0;
          else if (r_yel_run[i] != 8'hFF) r_yel_run[i] <= r_yel_run[i] + 8'd1;
          if (!w_bad[i])                 r_inv_cnt[i] <= 4'd0;
          else if (r_inv_cnt[i] != 4'hF)  r_inv_cnt[i] <= r_inv_cnt[i] + 4'd1;
        end
        if (r_cur != r_prev)        r_stall <= 8'd0;
        else if (r_stall != 8'hFF)  r_stall <= r_stall + 8'd1;
      end else begin
        r_yel_run <= '0;
        r_inv_cnt <= '0;
        r_stall   <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_MONITOR;
    else     r_state <= w_state_nxt;
  end

  // The all-red count uses the incoming sample, so the exit happens on the
  // edge that captures the ALLRED_CYC-th consecutive all-red vector.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_MONITOR: if (w_det) w_state_nxt = ST_FAULT;
      ST_FAULT:   if (fault_clear) w_state_nxt = ST_RECOVER;
      ST_RECOVER: if (w_in_allred && (r_allred == 8'(ALLRED_CYC - 1))) w_state_nxt = ST_MONITOR;
      default:    w_state_nxt = ST_MONITOR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_code  <= FC_NONE;
      fault_road  <= 2'd0;
      flash_on    <= 1'b0;
      fault_count <= 8'd0;
      r_flash_cnt <= 8'd0;
      r_allred    <= 8'd0;
    end else if (r_state == ST_MONITOR) begin
      if (w_det) begin
        fault_code  <= w_code;
        fault_road  <= w_road;
        flash_on    <= 1'b1;
        r_flash_cnt <= 8'd0;
        r_allred    <= 8'd0;
        if (fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
      end
    end else if (w_state_nxt == ST_MONITOR) begin
      fault_code  <= FC_NONE;
      fault_road  <= 2'd0;
      flash_on    <= 1'b0;
      r_flash_cnt <= 8'd0;
      r_allred    <= 8'd0;
    end else begin
      if (r_flash_cnt == 8'(FLASH_HALF - 1)) begin
        flash_on    <= ~flash_on;
        r_flash_cnt <= 8'd0;
      end else begin
        r_flash_cnt <= r_flash_cnt + 8'd1;
      end
      if (r_state == ST_RECOVER && w_in_allred) r_allred <= r_allred + 8'd1;
      else                                      r_allred <= 8'd0;
    end
  end

  assign fault      = (r_state != ST_MONITOR);
  assign monitor_ok = (r_state == ST_MONITOR);

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// -----------------------------------------------------------------------------
// tb_signal_conflict_monitor
//   Directed-vector bench for signal_conflict_monitor with default parameters.
//   Inputs change 1 time unit after a rising edge. Outputs are sampled at the
//   same point, so each check sees the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_signal_conflict_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] m1, m2, mt, sr;
  logic       preempt, fault_clear;
  logic       fault, flash_on, monitor_ok;
  logic [2:0] fault_code;
  logic [1:0] fault_road;
  logic [7:0] fault_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] nom_vec [6];
  int          nom_len [6];

  signal_conflict_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .main_road_1 (m1),
    .main_road_2 (m2),
    .main_turn   (mt),
    .side_road   (sr),
    .preempt     (preempt),
    .fault_clear (fault_clear),
    .fault       (fault),
    .fault_code  (fault_code),
    .fault_road  (fault_road),
    .flash_on    (flash_on),
    .fault_count (fault_count),
    .monitor_ok  (monitor_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Vector order is {side, turn, main2, main1}.
  task automatic set_vec(input logic [11:0] v);
    {sr, mt, m2, m1} = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_vec({R, R, R, R});
    preempt     = 1'b0;
    fault_clear = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic check_fault(input string tag, input logic [2:0] code, input logic [1:0] road);
    check({tag, "_fault"}, 32'(fault), 32'd1);
    check({tag, "_code"},  32'(fault_code), 32'(code));
    check({tag, "_road"},  32'(fault_road), 32'(road));
  endtask

  initial begin
    nom_vec = '{{R, R, G, G}, {R, R, Y, G}, {R, G, R, G},
                {R, Y, R, Y}, {G, R, R, R}, {Y, R, R, R}};
    nom_len = '{8, 3, 6, 3, 4, 3};

    // Reset values
    rst = 1'b1;
    set_vec({R, R, R, R});
    preempt     = 1'b0;
    fault_clear = 1'b0;
    tick(1);
    check("rst_fault",   32'(fault), 32'd0);
    check("rst_code",    32'(fault_code), 32'd0);
    check("rst_flash",   32'(flash_on), 32'd0);
    check("rst_count",   32'(fault_count), 32'd0);
    check("rst_ok",      32'(monitor_ok), 32'd1);

    // Nominal controller cycle, three rounds
    do_reset();
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int p = 0; p < 6; p++) begin
        set_vec(nom_vec[p]);
        tick(nom_len[p]);
      end
      check("nominal_fault", 32'(fault), 32'd0);
    end
    set_vec({R, R, R, R});
    tick(2);
    check("nominal_fault_end", 32'(fault), 32'd0);
    check("nominal_count", 32'(fault_count), 32'd0);

    // Conflict S/M2 for one sample
    do_reset();
    set_vec({G, R, G, R});
    tick(1);
    check("conflict_latency", 32'(fault), 32'd0);
    set_vec({R, R, R, R});
    tick(1);
    check_fault("conflict", 3'd1, 2'd1);
    check("conflict_count", 32'(fault_count), 32'd1);
    check("conflict_ok", 32'(monitor_ok), 32'd0);
    check("flash_p0", 32'(flash_on), 32'd1);
    tick(3);
    check("flash_p3", 32'(flash_on), 32'd1);
    tick(1);
    check("flash_p4", 32'(flash_on), 32'd0);
    tick(3);
    check("flash_p7", 32'(flash_on), 32'd0);
    tick(1);
    check("flash_p8", 32'(flash_on), 32'd1);

    // Detection frozen while in FAULT
    set_vec({R, R, R, 3'b011});
    tick(2);
    check("frozen_code", 32'(fault_code), 32'd1);
    check("frozen_road", 32'(fault_road), 32'd1);

    // Recovery: clear, 3 all-red, a green, then 4 all-red
    set_vec({R, R, R, R});
    fault_clear = 1'b1;
    tick(1);
    fault_clear = 1'b0;
    check("recover_fault", 32'(fault), 32'd1);
    check("recover_ok0", 32'(monitor_ok), 32'd0);
    tick(3);
    check("recover_3red", 32'(monitor_ok), 32'd0);
    set_vec({R, R, R, G});
    tick(1);
    check("recover_green", 32'(monitor_ok), 32'd0);
    set_vec({R, R, R, R});
    tick(3);
    check("recover_red3", 32'(monitor_ok), 32'd0);
    tick(1);
    check("recover_red4_ok", 32'(monitor_ok), 32'd1);
    check("recover_fault0", 32'(fault), 32'd0);
    check("recover_code0", 32'(fault_code), 32'd0);
    check("recover_road0", 32'(fault_road), 32'd0);
    check("recover_flash0", 32'(flash_on), 32'd0);
    check("recover_count", 32'(fault_count), 32'd1);

    // fault_clear in MONITOR has no effect
    fault_clear = 1'b1;
    tick(1);
    fault_clear = 1'b0;
    check("clear_in_monitor", 32'(monitor_ok), 32'd1);

    // Second conflict (MT/S) increments the count and reports road 2
    set_vec({G, G, R, R});
    tick(1);
    set_vec({R, R, R, R});
    tick(1);
    check_fault("conflict2", 3'd1, 2'd2);
    check("conflict2_count", 32'(fault_count), 32'd2);

    // Asynchronous reset mid-fault
    rst = 1'b1;
    #2;
    check("async_fault", 32'(fault), 32'd0);
    check("async_code", 32'(fault_code), 32'd0);
    check("async_flash", 32'(flash_on), 32'd0);
    check("async_count", 32'(fault_count), 32'd0);
    check("async_ok", 32'(monitor_ok), 32'd1);

    // Preempt masks skip-yellow; the same transition later faults
    do_reset();
    set_vec({R, R, G, R});
    tick(2);
    preempt = 1'b1;
    tick(2);
    set_vec({R, R, R, R});
    tick(2);
    preempt = 1'b0;
    tick(3);
    check("preempt_masked", 32'(fault), 32'd0);
    tick(17);
    check("preempt_hold_idle", 32'(fault), 32'd0);
    set_vec({R, R, G, R});
    tick(1);
    set_vec({R, R, R, R});
    tick(1);
    check("skip_latency", 32'(fault), 32'd0);
    tick(1);
    check_fault("skip", 3'd3, 2'd1);

    // Short yellow on MT (2 samples)
    do_reset();
    set_vec({R, G, R, R});
    tick(1);
    set_vec({R, Y, R, R});
    tick(2);
    set_vec({R, R, R, R});
    tick(1);
    check("short_latency", 32'(fault), 32'd0);
    tick(1);
    check_fault("short", 3'd4, 2'd2);

    // Exactly MIN_YELLOW yellow samples is legal
    do_reset();
    set_vec({R, G, R, R});
    tick(1);
    set_vec({R, Y, R, R});
    tick(3);
    set_vec({R, R, R, R});
    tick(3);
    check("yellow3_ok", 32'(fault), 32'd0);

    // Yellow straight to green on M1
    do_reset();
    set_vec({R, R, R, Y});
    tick(3);
    set_vec({R, R, R, G});
    tick(2);
    check_fault("y2g", 3'd5, 2'd0);

    // Malformed M1 aspect for one sample
    do_reset();
    set_vec({R, R, R, 3'b011});
    tick(1);
    set_vec({R, R, R, R});
    tick(1);
    check_fault("invalid", 3'd2, 2'd0);

    // Stall: unchanged vector for MAX_STUCK cycles
    do_reset();
    tick(31);
    check("stuck_31", 32'(fault), 32'd0);
    tick(1);
    check_fault("stuck", 3'd6, 2'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
